// File: rtl/usb_trans_sched.sv
// Master-side USB 2.0 transaction scheduler: sequences token, data and handshake
// phases through the link controller, with retry, data-toggle tracking and completion status.
//
// state | meaning
// IDLE  | waiting for a request; toggle_clr honoured here
// TOK   | token PID pulse (OUT or IN)
// TOK_W | wait for token transmit EOP
// DAT   | DATA0/DATA1 PID pulse (OUT)
// DAT_W | wait for data transmit EOP
// HS_W  | wait for device handshake or timeout (OUT)
// RXD_W | wait for device data PID or timeout (IN)
// RXD_E | wait for end of received data packet
// ACK   | ACK PID pulse (IN)
// ACK_W | wait for ACK transmit EOP
// GAP   | idle gap before re-issuing the token
// DONE  | one-cycle completion pulse
module usb_trans_sched #(
    parameter int MAX_RETRY = 3,
    parameter int RETRY_GAP = 16,
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ms,
    input  logic          req_valid,
    input  logic          req_dir,
    output logic          req_ready,
    input  logic          toggle_clr,
    output logic [3:0]    tx_con_pid,
    output logic          tx_con_pid_en,
    input  logic          tx_lp_eop_en,
    input  logic [3:0]    rx_pid,
    input  logic          rx_pid_en,
    input  logic          rx_eop_en,
    input  logic          time_out,
    output logic          done_valid,
    output logic [1:0]    done_status,
    output logic [RW-1:0] retry_cnt,
    output logic          toggle
);

    localparam int GW = (RETRY_GAP < 2) ? 1 : $clog2(RETRY_GAP);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_TOK   = 4'd1;
    localparam logic [3:0] S_TOK_W = 4'd2;
    localparam logic [3:0] S_DAT   = 4'd3;
    localparam logic [3:0] S_DAT_W = 4'd4;
    localparam logic [3:0] S_HS_W  = 4'd5;
    localparam logic [3:0] S_RXD_W = 4'd6;
    localparam logic [3:0] S_RXD_E = 4'd7;
    localparam logic [3:0] S_ACK   = 4'd8;
    localparam logic [3:0] S_ACK_W = 4'd9;
    localparam logic [3:0] S_GAP   = 4'd10;
    localparam logic [3:0] S_DONE  = 4'd11;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_STALL = 2'b01;
    localparam logic [1:0] ST_FAIL  = 2'b10;
    localparam logic [1:0] ST_ABORT = 2'b11;

    logic [3:0]    state, state_nxt;
    logic [GW-1:0] gap_cnt;
    logic          dir_q;
    logic          match_q, match_nxt, match_ld;
    logic          rdy_en;
    logic          pid_ld;
    logic [3:0]    pid_nxt;
    logic          retry_req, retry_go;
    logic          fin;
    logic [1:0]    fin_status;
    logic          flip;
    logic          accept;

    // rdy_en keeps req_ready low during and the cycle right after reset
    assign req_ready     = (state == S_IDLE) && ms && rdy_en;
    assign accept        = req_valid && req_ready;
    assign tx_con_pid_en = (state == S_TOK) || (state == S_DAT) || (state == S_ACK);
    assign done_valid    = (state == S_DONE);

    always_comb begin
        state_nxt  = state;
        pid_ld     = 1'b0;
        pid_nxt    = tx_con_pid;
        retry_req  = 1'b0;
        retry_go   = 1'b0;
        fin        = 1'b0;
        fin_status = ST_OK;
        flip       = 1'b0;
        match_ld   = 1'b0;
        match_nxt  = match_q;
        if (!ms && (state != S_IDLE) && (state != S_DONE)) begin
            fin        = 1'b1;
            fin_status = ST_ABORT;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state_nxt = S_TOK;
                        pid_ld    = 1'b1;
                        pid_nxt   = req_dir ? PID_IN : PID_OUT;
                    end
                end
                S_TOK: state_nxt = S_TOK_W;
                S_TOK_W: begin
                    if (tx_lp_eop_en) begin
                        if (dir_q) begin
                            state_nxt = S_RXD_W;
                        end else begin
                            state_nxt = S_DAT;
                            pid_ld    = 1'b1;
                            pid_nxt   = toggle ? PID_DATA1 : PID_DATA0;
                        end
                    end
                end
                S_DAT: state_nxt = S_DAT_W;
                S_DAT_W: begin
                    if (tx_lp_eop_en) state_nxt = S_HS_W;
                end
                S_HS_W: begin
                    if (rx_pid_en) begin
                        if (rx_pid == PID_ACK) begin
                            flip = 1'b1;
                            fin  = 1'b1;
                        end else if (rx_pid == PID_STALL) begin
                            fin        = 1'b1;
                            fin_status = ST_STALL;
                        end else begin
                            retry_req = 1'b1;
                        end
                    end else if (time_out) begin
                        retry_req = 1'b1;
                    end
                end
                S_RXD_W: begin
                    if (rx_pid_en) begin
                        if (rx_pid[2:0] == 3'b011) begin
                            state_nxt = S_RXD_E;
                            match_ld  = 1'b1;
                            match_nxt = (rx_pid[3] == toggle);
                        end else if (rx_pid == PID_STALL) begin
                            fin        = 1'b1;
                            fin_status = ST_STALL;
                        end else begin
                            retry_req = 1'b1;
                        end
                    end else if (time_out) begin
                        retry_req = 1'b1;
                    end
                end
                S_RXD_E: begin
                    if (rx_eop_en) begin
                        state_nxt = S_ACK;
                        pid_ld    = 1'b1;
                        pid_nxt   = PID_ACK;
                    end else if (time_out) begin
                        retry_req = 1'b1;
                    end
                end
                S_ACK: state_nxt = S_ACK_W;
                S_ACK_W: begin
                    if (tx_lp_eop_en) begin
                        // a wrong-toggle packet is still ACKed, then re-requested
                        if (match_q) begin
                            flip = 1'b1;
                            fin  = 1'b1;
                        end else begin
                            retry_req = 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state_nxt = S_TOK;
                        pid_ld    = 1'b1;
                        pid_nxt   = dir_q ? PID_IN : PID_OUT;
                    end
                end
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
            if (retry_req) begin
                if (retry_cnt == RW'(MAX_RETRY)) begin
                    fin        = 1'b1;
                    fin_status = ST_FAIL;
                end else begin
                    retry_go  = 1'b1;
                    state_nxt = S_GAP;
                end
            end
        end
        if (fin) state_nxt = S_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            gap_cnt     <= '0;
            dir_q       <= 1'b0;
            match_q     <= 1'b0;
            rdy_en      <= 1'b0;
            tx_con_pid  <= 4'b0000;
            done_status <= 2'b00;
            retry_cnt   <= '0;
            toggle      <= 1'b0;
        end else begin
            state  <= state_nxt;
            rdy_en <= 1'b1;
            if (pid_ld) tx_con_pid <= pid_nxt;
            if (fin) done_status <= fin_status;
            if (match_ld) match_q <= match_nxt;
            if (accept) begin
                dir_q     <= req_dir;
                retry_cnt <= '0;
            end else if (retry_go) begin
                retry_cnt <= retry_cnt + RW'(1);
            end
            if ((state == S_IDLE) && toggle_clr) toggle <= 1'b0;
            else if (flip) toggle <= ~toggle;
            if (retry_go) gap_cnt <= GW'(RETRY_GAP - 1);
            else if ((state == S_GAP) && (gap_cnt != '0)) gap_cnt <= gap_cnt - GW'(1);
        end
    end

endmodule

// File: tb/tb_usb_trans_sched.sv
// Self-checking bench for usb_trans_sched: a scoreboard of expected PID pulses
// plus per-scenario checks of status, toggle, retry count and timing.
module tb_usb_trans_sched;
    localparam int G = 16;
    localparam logic [3:0] P_OUT = 4'b0001, P_IN = 4'b1001, P_ACK = 4'b0010,
                           P_NAK = 4'b1010, P_STALL = 4'b1110;

    logic clk = 0, rst_n = 0, ms = 1, req_valid = 0, req_dir = 0, toggle_clr = 0;
    logic tx_lp_eop_en = 0, rx_pid_en = 0, rx_eop_en = 0, time_out = 0;
    logic [3:0] rx_pid = 0;
    logic req_ready, tx_con_pid_en, done_valid, toggle;
    logic [3:0] tx_con_pid;
    logic [1:0] done_status, retry_cnt;

    int checks = 0, errors = 0, cyc = 0;
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;
    logic mdl_tog = 0;

    usb_trans_sched #(.MAX_RETRY(3), .RETRY_GAP(G)) dut (
        .clk(clk), .rst_n(rst_n), .ms(ms), .req_valid(req_valid), .req_dir(req_dir),
        .req_ready(req_ready), .toggle_clr(toggle_clr), .tx_con_pid(tx_con_pid),
        .tx_con_pid_en(tx_con_pid_en), .tx_lp_eop_en(tx_lp_eop_en), .rx_pid(rx_pid),
        .rx_pid_en(rx_pid_en), .rx_eop_en(rx_eop_en), .time_out(time_out),
        .done_valid(done_valid), .done_status(done_status), .retry_cnt(retry_cnt),
        .toggle(toggle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: every PID pulse pops the next expected PID
    always @(negedge clk) begin
        if (rst_n && tx_con_pid_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pid: got %b, required no pulse (cycle %0d)", tx_con_pid, cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                if (tx_con_pid !== mon_exp) begin
                    errors++;
                    $display("FAIL pid: got %b, required %b (cycle %0d)", tx_con_pid, mon_exp, cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end, required finish");
        $fatal(1);
    end

    task automatic start_req(input logic dir, input logic clr);
        exp_q.push_back(dir ? P_IN : P_OUT);
        req_valid = 1; req_dir = dir; toggle_clr = clr;
        @(negedge clk);
        req_valid = 0; toggle_clr = 0;
    endtask

    task automatic link_eop();
        repeat (2) @(negedge clk);
        tx_lp_eop_en = 1;
        @(negedge clk);
        tx_lp_eop_en = 0;
    endtask

    task automatic send_pid(input logic [3:0] p);
        rx_pid = p; rx_pid_en = 1;
        @(negedge clk);
        rx_pid_en = 0;
    endtask

    task automatic send_to();
        time_out = 1;
        @(negedge clk);
        time_out = 0;
    endtask

    task automatic send_rx_eop();
        rx_eop_en = 1;
        @(negedge clk);
        rx_eop_en = 0;
    endtask

    task automatic wait_pulse(output int at);
        int n;
        n = 0;
        while (!tx_con_pid_en && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!tx_con_pid_en) begin
            errors++;
            $display("FAIL pulse_timeout: got no pulse, required tx_con_pid_en");
        end
        at = cyc;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, tx_con_pid_en, done_valid, toggle, retry_cnt, tx_con_pid, done_status} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b en=%b dv=%b tog=%b rc=%0d pid=%b st=%b, required all 0",
                     req_ready, tx_con_pid_en, done_valid, toggle, retry_cnt, tx_con_pid, done_status);
        end
        rst_n = 1;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_out_ok(input logic clr);
        int c, at;
        if (clr) mdl_tog = 0;
        c = cyc;
        start_req(0, clr);
        wait_pulse(at);
        checks++;
        if (at !== c + 1) begin
            errors++;
            $display("FAIL tok_latency: got %0d, required %0d", at - c, 1);
        end
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready: got %b, required 0", req_ready);
        end
        exp_q.push_back({mdl_tog, 3'b011});
        link_eop();
        wait_pulse(at);
        link_eop();
        send_pid(P_ACK);
        mdl_tog = ~mdl_tog;
        checks++;
        if (done_valid !== 1'b1 || done_status !== 2'b00) begin
            errors++;
            $display("FAIL out_done: got dv=%b st=%b, required dv=1 st=00", done_valid, done_status);
        end
        checks++;
        if (toggle !== mdl_tog || retry_cnt !== 2'd0) begin
            errors++;
            $display("FAIL out_state: got tog=%b rc=%0d, required tog=%b rc=0", toggle, retry_cnt, mdl_tog);
        end
        @(negedge clk);
        checks++;
        if (done_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL out_pulse_end: got dv=%b pending=%0d, required dv=0 pending=0", done_valid, exp_q.size());
        end
    endtask

    task automatic test_in_ok();
        int at;
        start_req(1, 0);
        wait_pulse(at);
        link_eop();
        // DATA PID and timeout together: the PID must win
        rx_pid = {mdl_tog, 3'b011}; rx_pid_en = 1; time_out = 1;
        @(negedge clk);
        rx_pid_en = 0; time_out = 0;
        exp_q.push_back(P_ACK);
        send_rx_eop();
        link_eop();
        mdl_tog = ~mdl_tog;
        checks++;
        if (done_valid !== 1'b1 || done_status !== 2'b00 || toggle !== mdl_tog) begin
            errors++;
            $display("FAIL in_done: got dv=%b st=%b tog=%b, required dv=1 st=00 tog=%b",
                     done_valid, done_status, toggle, mdl_tog);
        end
        @(negedge clk);
    endtask

    task automatic test_nak_retry();
        int at, k;
        start_req(0, 0);
        wait_pulse(at);
        for (int a = 0; a < 3; a++) begin
            exp_q.push_back({mdl_tog, 3'b011});
            link_eop();
            wait_pulse(at);
            link_eop();
            if (a < 2) begin
                exp_q.push_back(P_OUT);
                k = cyc;
                send_pid(P_NAK);
                wait_pulse(at);
                checks++;
                if (at - k !== G + 1) begin
                    errors++;
                    $display("FAIL nak_gap: got %0d, required %0d", at - k, G + 1);
                end
            end else begin
                send_pid(P_ACK);
            end
        end
        mdl_tog = ~mdl_tog;
        checks++;
        if (done_valid !== 1'b1 || done_status !== 2'b00 || retry_cnt !== 2'd2 || toggle !== mdl_tog) begin
            errors++;
            $display("FAIL nak_done: got dv=%b st=%b rc=%0d tog=%b, required dv=1 st=00 rc=2 tog=%b",
                     done_valid, done_status, retry_cnt, toggle, mdl_tog);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout_fail();
        int at, k;
        start_req(1, 0);
        wait_pulse(at);
        for (int a = 0; a < 4; a++) begin
            link_eop();
            if (a < 3) exp_q.push_back(P_IN);
            k = cyc;
            send_to();
            if (a < 3) begin
                wait_pulse(at);
                checks++;
                if (at - k !== G + 1) begin
                    errors++;
                    $display("FAIL to_gap: got %0d, required %0d", at - k, G + 1);
                end
            end
        end
        checks++;
        if (done_valid !== 1'b1 || done_status !== 2'b10 || retry_cnt !== 2'd3 || toggle !== mdl_tog) begin
            errors++;
            $display("FAIL to_fail: got dv=%b st=%b rc=%0d tog=%b, required dv=1 st=10 rc=3 tog=%b",
                     done_valid, done_status, retry_cnt, toggle, mdl_tog);
        end
        @(negedge clk);
    endtask

    task automatic test_toggle_mismatch();
        int at;
        start_req(1, 0);
        wait_pulse(at);
        link_eop();
        send_pid({~mdl_tog, 3'b011});
        exp_q.push_back(P_ACK);
        send_rx_eop();
        exp_q.push_back(P_IN);
        link_eop();
        checks++;
        if (done_valid !== 1'b0 || toggle !== mdl_tog || retry_cnt !== 2'd1) begin
            errors++;
            $display("FAIL mm_retry: got dv=%b tog=%b rc=%0d, required dv=0 tog=%b rc=1",
                     done_valid, toggle, retry_cnt, mdl_tog);
        end
        wait_pulse(at);
        link_eop();
        send_pid({mdl_tog, 3'b011});
        exp_q.push_back(P_ACK);
        send_rx_eop();
        link_eop();
        mdl_tog = ~mdl_tog;
        checks++;
        if (done_valid !== 1'b1 || done_status !== 2'b00 || toggle !== mdl_tog || retry_cnt !== 2'd1) begin
            errors++;
            $display("FAIL mm_done: got dv=%b st=%b tog=%b rc=%0d, required dv=1 st=00 tog=%b rc=1",
                     done_valid, done_status, toggle, retry_cnt, mdl_tog);
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        int at;
        start_req(0, 0);
        wait_pulse(at);
        exp_q.push_back({mdl_tog, 3'b011});
        link_eop();
        wait_pulse(at);
        link_eop();
        send_pid(P_STALL);
        checks++;
        if (done_valid !== 1'b1 || done_status !== 2'b01 || toggle !== mdl_tog) begin
            errors++;
            $display("FAIL stall: got dv=%b st=%b tog=%b, required dv=1 st=01 tog=%b",
                     done_valid, done_status, toggle, mdl_tog);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int at;
        start_req(0, 0);
        wait_pulse(at);
        exp_q.push_back({mdl_tog, 3'b011});
        link_eop();
        wait_pulse(at);
        link_eop();
        ms = 0; rx_pid = P_ACK; rx_pid_en = 1;
        @(negedge clk);
        rx_pid_en = 0;
        checks++;
        if (done_valid !== 1'b1 || done_status !== 2'b11 || toggle !== mdl_tog) begin
            errors++;
            $display("FAIL abort: got dv=%b st=%b tog=%b, required dv=1 st=11 tog=%b",
                     done_valid, done_status, toggle, mdl_tog);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL slave_ready: got %b, required 0", req_ready);
        end
        ms = 1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL master_ready: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_reset_gap();
        int at;
        bit seen;
        @(negedge clk);
        start_req(0, 0);
        wait_pulse(at);
        exp_q.push_back({mdl_tog, 3'b011});
        link_eop();
        wait_pulse(at);
        link_eop();
        send_pid(P_NAK);
        repeat (3) @(negedge clk);
        #2 rst_n = 0;
        #1;
        checks++;
        if ({req_ready, tx_con_pid_en, done_valid, toggle, retry_cnt, tx_con_pid, done_status} !== 12'h000) begin
            errors++;
            $display("FAIL gap_reset: got rdy=%b en=%b dv=%b tog=%b rc=%0d pid=%b st=%b, required all 0",
                     req_ready, tx_con_pid_en, done_valid, toggle, retry_cnt, tx_con_pid, done_status);
        end
        @(negedge clk);
        rst_n = 1;
        mdl_tog = 0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_valid) seen = 1;
        end
        checks++;
        if (seen || exp_q.size() != 0) begin
            errors++;
            $display("FAIL post_reset: got done=%b pending=%0d, required done=0 pending=0", seen, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_out_ok(0);
        test_in_ok();
        test_nak_retry();
        test_timeout_fail();
        test_toggle_mismatch();
        test_out_ok(0);
        test_out_ok(1);
        test_stall();
        test_abort();
        test_reset_gap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_trans_sched.md
# usb_trans_sched

Master-side transaction scheduler for the USB 2.0 link layer. Accepts one OUT or IN transaction request at a time and drives the link controller through token, data and handshake phases. Retries on NAK, timeout or data-toggle mismatch, tracks the DATA0/DATA1 toggle, and reports a completion status. It sits between the host-side request logic and `link_control`: it drives `tx_con_pid`/`tx_con_pid_en` and consumes `rx_pid`/`rx_pid_en`/`time_out`.

## Interface
- `MAX_RETRY`, default 3: number of retries allowed after the first attempt fails.
- `RETRY_GAP`, default 16: idle cycles between a failed attempt and its re-issue. Must be ≥1.
- `clk` in 1: single clock. All logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ms` in 1: 1 means master mode. The block operates only when this is 1.
- `req_valid` in 1: transaction request.
- `req_dir` in 1: 0 means OUT, 1 means IN. Sampled at accept.
- `req_ready` out 1: request accepted when `req_valid & req_ready`.
- `toggle_clr` in 1: forces the data toggle to 0. Honoured in IDLE only.
- `tx_con_pid` out 4: PID for the link to transmit.
- `tx_con_pid_en` out 1: one-cycle pulse that starts a transmission.
- `tx_lp_eop_en` in 1: pulse when the link finishes transmitting a packet.
- `rx_pid` in 4, `rx_pid_en` in 1: received PID, valid on the pulse.
- `rx_eop_en` in 1: pulse at the end of a received packet.
- `time_out` in 1: pulse from the link when the response timer expires.
- `done_valid` out 1: one-cycle completion pulse.
- `done_status` out 2: 00 OK, 01 STALL, 10 FAIL (retries exhausted), 11 ABORT. Held until the next `done_valid`.
- `retry_cnt` out 2..: width is clog2(MAX_RETRY+1). Retries used by the current or last transaction.
- `toggle` out 1: current expected or used data toggle.

## Operation
- PID encodings:
  - Tokens: OUT=0001, IN=1001.
  - Data: DATA0=0011, DATA1=1011.
  - Handshakes: ACK=0010, NAK=1010, STALL=1110.
- States: IDLE, TOK, TOK_W, DAT, DAT_W, HS_W, RXD_W, RXD_E, ACK, ACK_W, GAP, DONE.
- IDLE:
  - `req_ready = ms`.
  - On accept, latch `req_dir`, clear `retry_cnt`, go to TOK.
  - `toggle_clr` sets `toggle` to 0.
- TOK: pulse `tx_con_pid_en` with the OUT or IN token, then go to TOK_W.
- TOK_W: wait for `tx_lp_eop_en`. OUT goes to DAT; IN goes to RXD_W.
- DAT and DAT_W: pulse DATA0 or DATA1 according to `toggle`, wait for `tx_lp_eop_en`, then go to HS_W.
- HS_W, on a received PID or timeout:
  - ACK: flip `toggle`, status OK.
  - STALL: status STALL, `toggle` unchanged.
  - NAK, any other PID, or `time_out`: go to the retry path.
- RXD_W:
  - DATA PID whose toggle bit equals `toggle`: go to RXD_E and mark a match.
  - DATA PID with the wrong toggle bit: go to RXD_E and mark a mismatch.
  - NAK: retry path.
  - STALL: status STALL.
  - Any other PID or `time_out`: retry path.
- RXD_E:
  - Wait for `rx_eop_en`, then go to ACK.
  - A `time_out` here goes to the retry path; no ACK is sent.
- ACK and ACK_W:
  - Pulse an ACK PID and wait for `tx_lp_eop_en`.
  - On a match, flip `toggle` and complete with OK.
  - On a mismatch, take the retry path with `toggle` unchanged.
- Retry path:
  - If `retry_cnt == MAX_RETRY`, status is FAIL and the block goes to DONE.
  - Otherwise increment `retry_cnt`, go to GAP, count RETRY_GAP cycles, then return to TOK.
- DONE: `done_valid` is high for one cycle, then the block returns to IDLE.
- Abort: `ms` falling in any state other than IDLE or DONE sends the block to DONE with status ABORT. `toggle` is unchanged.
- A `tx_con_pid_en` pulse lasts one cycle. `tx_con_pid` holds its value until the next pulse.

## Timing
- Reset values:
  - State is IDLE.
  - `req_ready`, `tx_con_pid_en`, `done_valid`, `toggle` and `retry_cnt` are 0.
  - `tx_con_pid` and `done_status` are 0000 and 00.
- Latency from request and response:
  - Accept at cycle N gives the token `tx_con_pid_en` at N+1.
  - A transmit EOP at cycle M gives the next PID pulse, or the move to a wait state, at M+1.
  - A handshake at cycle K gives `done_valid` at K+1.
- Retry re-issue: `tx_con_pid_en` comes exactly RETRY_GAP+1 cycles after the failing event.
- Simultaneous events:
  - `rx_pid_en` together with `time_out`: the PID wins.
  - `ms` falling together with any event: abort wins.
  - `toggle_clr` together with an accept: the clear applies before the transaction.
- Asynchronous reset mid-transaction returns the block to IDLE immediately. No `done_valid` is produced.
- `req_ready` is 0 in every state except IDLE. `req_valid` is ignored outside IDLE.

## Test plan
- OUT with `toggle`=0 and ACK:
  - Expect PID pulses 0001 then 0011.
  - Expect `done_status`=00, `toggle`=1, `retry_cnt`=0.
- IN with `toggle`=1, device returns DATA1 then EOP:
  - Expect an ACK (0010) pulse, `done_status`=00, `toggle`=0.
- OUT with NAK ×2 then ACK:
  - Expect 3 token pulses, each re-issue RETRY_GAP+1=17 cycles after the NAK.
  - Expect `retry_cnt`=2, status 00.
- IN with `time_out` ×4 and MAX_RETRY=3:
  - Expect 4 tokens, then `done_status`=10 and `retry_cnt`=3.
- IN with wrong toggle (DATA0 received while `toggle`=1):
  - Expect an ACK sent, a retry, `toggle` still 1.
  - Then DATA1 completes OK.
- STALL, abort and reset:
  - STALL on OUT gives status 01.
  - `ms` dropping in HS_W gives status 11 next cycle.
  - `rst_n` low in GAP clears all outputs asynchronously.
